calc_sequencer: RTL and testbench

Control block for the calculator datapath. Captures two operands from switch inputs on load strobes and runs a bit-serial add or subtract over WIDTH cycles. Writes the WIDTH+1-bit result (sum plus carry/borrow) into an enabled result register and holds it for display. Sits between the debounced button/switch front end and the 7-segment/LED output stage.

---
 rtl/calc_pkg.sv | 18 +
 rtl/calc_result_reg.sv | 28 ++
 rtl/calc_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_calc_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: state and operation
// encodings plus the default operand width.
package calc_pkg;

  localparam int CALC_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

endpackage

// File: rtl/calc_result_reg.sv
// Enabled result register with asynchronous active-low reset. Holds the
// WIDTH+1-bit result (carry/borrow in the MSB) for the display stage.
module calc_result_reg
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic [WIDTH:0] d,
  output logic [WIDTH:0] q
);

  logic [WIDTH:0] r_q;

  // Capture d only when enabled; otherwise hold for display.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (enable) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control block: captures operands A and B on load strobes and
// runs a bit-serial add or subtract over WIDTH cycles, then parks the
// WIDTH+1-bit result in calc_result_reg.
//
// Strobe semantics: load_a, load_b, start and clear are single-cycle
// strobes sampled on the rising edge of clk; there is no ready/ack. When
// several are high in the same cycle only the highest-priority one acts
// (clear > start > load_a > load_b) and the rest are dropped. In COMPUTE
// only clear is honoured. A start without both operands loaded is
// answered with a one-cycle err pulse in the following cycle.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] operand,
  input  logic             op_sub,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             start,
  input  logic             clear,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic             busy,
  output logic             err,
  output logic [1:0]       state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_a_ok;
  logic             r_b_ok;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-2:0] r_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  op_t              r_op;
  logic             r_err;

  logic             w_start_go;
  logic             w_start_rej;
  logic             w_cap_a;
  logic             w_cap_b;
  logic             w_res_en;
  logic [WIDTH:0]   w_res_d;
  logic             w_sum_bit;
  logic             w_cout;
  logic             w_msb;
  logic             w_last;

  // Serial full adder on the LSBs of the shift registers.
  always_comb begin
    w_sum_bit = r_sa[0] ^ r_sb[0] ^ r_carry;
    w_cout    = (r_sa[0] & r_sb[0]) | (r_carry & (r_sa[0] ^ r_sb[0]));
    // Subtract runs as A + ~B + 1, so the carry out is the inverse of borrow.
    w_msb     = (r_op == OP_SUB) ? ~w_cout : w_cout;
    w_last    = (r_cnt == CW'(WIDTH - 1));
    w_res_d   = clear ? '0 : {w_msb, w_sum_bit, r_sr};
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control decode, applying strobe priority.
  always_comb begin
    w_next      = r_state;
    w_start_go  = 1'b0;
    w_start_rej = 1'b0;
    w_cap_a     = 1'b0;
    w_cap_b     = 1'b0;
    w_res_en    = 1'b0;
    if (clear) begin
      w_next   = ST_IDLE;
      w_res_en = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (r_a_ok && r_b_ok) begin
              w_start_go = 1'b1;
              w_next     = ST_COMPUTE;
            end else begin
              w_start_rej = 1'b1;
            end
          end else if (load_a) begin
            w_cap_a = 1'b1;
          end else if (load_b) begin
            w_cap_b = 1'b1;
          end
        end
        ST_COMPUTE: begin
          if (w_last) begin
            w_res_en = 1'b1;
            w_next   = ST_DONE;
          end
        end
        ST_DONE: begin
          // Both flags are necessarily set here, so start always proceeds.
          if (start) begin
            w_start_go = 1'b1;
            w_next     = ST_COMPUTE;
          end else if (load_a) begin
            w_cap_a = 1'b1;
            w_next  = ST_IDLE;
          end else if (load_b) begin
            w_cap_b = 1'b1;
            w_next  = ST_IDLE;
          end
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  // Operand capture, serial datapath and err pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_a_ok  <= 1'b0;
      r_b_ok  <= 1'b0;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_op    <= OP_ADD;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_start_rej;
      if (clear) begin
        r_a    <= '0;
        r_b    <= '0;
        r_a_ok <= 1'b0;
        r_b_ok <= 1'b0;
      end else if (w_start_go) begin
        r_sa    <= r_a;
        r_sb    <= op_sub ? ~r_b : r_b;
        r_sr    <= '0;
        r_carry <= op_sub;
        r_cnt   <= '0;
        r_op    <= op_sub ? OP_SUB : OP_ADD;
      end else if (w_cap_a) begin
        r_a    <= operand;
        r_a_ok <= 1'b1;
      end else if (w_cap_b) begin
        r_b    <= operand;
        r_b_ok <= 1'b1;
      end else if (r_state == ST_COMPUTE) begin
        r_sr    <= {w_sum_bit, r_sr[WIDTH-2:1]};
        r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
        r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
        r_carry <= w_cout;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  calc_result_reg #(
    .WIDTH (WIDTH)
  ) u_result_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (w_res_en),
    .d       (w_res_d),
    .q       (result)
  );

  assign result_valid = (r_state == ST_DONE);
  assign busy         = (r_state == ST_COMPUTE);
  assign err          = r_err;
  assign state        = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios followed by randomized
// load/start sequences, checked against an arithmetic reference model.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int W  = 4;
  localparam int RW = W + 1;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] operand;
  logic         op_sub;
  logic         load_a;
  logic         load_b;
  logic         start;
  logic         clear;
  logic [W:0]   result;
  logic         result_valid;
  logic         busy;
  logic         err;
  logic [1:0]   state;

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard and operand model.
  logic [W:0]   exp_q[$];
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic         m_a_ok;
  logic         m_b_ok;

  calc_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .operand      (operand),
    .op_sub       (op_sub),
    .load_a       (load_a),
    .load_b       (load_b),
    .start        (start),
    .clear        (clear),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .err          (err),
    .state        (state)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: add gives the plain WIDTH+1-bit sum; subtract gives
  // (A-B) mod 2^W with borrow = A<B in the MSB.
  function automatic logic [W:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
    if (sub) ref_calc = {(ai < bi) ? 1'b1 : 1'b0, W'(ai - bi)};
    else     ref_calc = RW'(ai + bi);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_a    = '0;
    m_b    = '0;
    m_a_ok = 1'b0;
    m_b_ok = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_valid"},  32'(result_valid), 32'd0);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_err"},    32'(err), 32'd0);
    check({tag, "_state"},  32'(state), 32'd0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    repeat (2) step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    model_reset();
  endtask

  task automatic load_a_op(input logic [W-1:0] v);
    operand = v;
    load_a  = 1'b1;
    step();
    load_a  = 1'b0;
    m_a     = v;
    m_a_ok  = 1'b1;
  endtask

  task automatic load_b_op(input logic [W-1:0] v);
    operand = v;
    load_b  = 1'b1;
    step();
    load_b  = 1'b0;
    m_b     = v;
    m_b_ok  = 1'b1;
  endtask

  task automatic start_op(input logic sub, output logic accepted);
    op_sub = sub;
    start  = 1'b1;
    step();
    start  = 1'b0;
    accepted = m_a_ok && m_b_ok;
    if (accepted) exp_q.push_back(ref_calc(m_a, m_b, sub));
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_reset();
    check_all_zero(tag);
  endtask

  // Called 'already' edges after the start edge; follows busy to completion.
  task automatic expect_compute(input string tag, input int already);
    logic [W:0] e;
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    check({tag, "_state0"}, 32'(state), 32'(ST_COMPUTE));
    check({tag, "_valid0"}, 32'(result_valid), 32'd0);
    for (int i = already; i < W - 1; i++) begin
      step();
      check({tag, "_busy"}, 32'(busy), 32'd1);
    end
    step();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_state_end"}, 32'(state), 32'(ST_DONE));
    check({tag, "_valid"}, 32'(result_valid), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(e));
  endtask

  task automatic expect_reject(input string tag);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_state"}, 32'(state), 32'(ST_IDLE));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    step();
    check({tag, "_err_drop"}, 32'(err), 32'd0);
  endtask

  task automatic run_calc(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub);
    logic acc;
    load_a_op(a);
    load_b_op(b);
    start_op(sub, acc);
    expect_compute(tag, 0);
  endtask

  // Directed and randomized sequence.
  initial begin
    logic         acc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    reset_n = 1'b1;
    operand = '0;
    op_sub  = 1'b0;
    load_a  = 1'b0;
    load_b  = 1'b0;
    start   = 1'b0;
    clear   = 1'b0;
    model_reset();
    #2;
    apply_reset();
    check_all_zero("reset");

    // Test-plan arithmetic.
    run_calc("add_9_5", 4'd9, 4'd5, 1'b0);
    check("add_9_5_const", 32'(result), 32'b01110);
    run_calc("add_12_7", 4'd12, 4'd7, 1'b0);
    check("add_12_7_const", 32'(result), 32'b10011);
    run_calc("sub_3_5", 4'd3, 4'd5, 1'b1);
    check("sub_3_5_const", 32'(result), 32'b11110);
    run_calc("sub_5_3", 4'd5, 4'd3, 1'b1);
    check("sub_5_3_const", 32'(result), 32'b00010);

    // Back-to-back start straight out of DONE.
    start_op(1'b0, acc);
    expect_compute("b2b", 0);
    check("b2b_const", 32'(result), 32'd8);

    // Load in DONE: back to IDLE, result held, B kept.
    load_a_op(4'd10);
    check("done_load_valid", 32'(result_valid), 32'd0);
    check("done_load_state", 32'(state), 32'(ST_IDLE));
    check("done_load_hold", 32'(result), 32'd8);
    start_op(1'b1, acc);
    expect_compute("keep_b", 0);
    check("keep_b_const", 32'(result), 32'd7);

    // start beats load_a in the same cycle.
    operand = 4'd15;
    op_sub  = 1'b0;
    load_a  = 1'b1;
    start   = 1'b1;
    step();
    load_a  = 1'b0;
    start   = 1'b0;
    exp_q.push_back(ref_calc(m_a, m_b, 1'b0));
    expect_compute("prio_start", 0);
    check("prio_start_const", 32'(result), 32'd13);

    // load_a beats load_b in the same cycle.
    operand = 4'd6;
    load_a  = 1'b1;
    load_b  = 1'b1;
    step();
    load_a  = 1'b0;
    load_b  = 1'b0;
    m_a     = 4'd6;
    start_op(1'b0, acc);
    expect_compute("prio_load", 0);
    check("prio_load_const", 32'(result), 32'd9);

    // clear beats start; flags are gone afterwards.
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    model_reset();
    check_all_zero("prio_clear");
    start_op(1'b0, acc);
    expect_reject("after_clear");

    // Missing operand after reset.
    apply_reset();
    load_a_op(4'd4);
    start_op(1'b0, acc);
    check("rej_accepted", 32'(acc), 32'd0);
    check("rej_result", 32'(result), 32'd0);
    check("rej_valid", 32'(result_valid), 32'd0);
    expect_reject("rej");

    // COMPUTE ignores load_a and start (no err).
    load_b_op(4'd2);
    start_op(1'b0, acc);
    operand = 4'd15;
    load_a  = 1'b1;
    start   = 1'b1;
    step();
    load_a  = 1'b0;
    start   = 1'b0;
    check("ign_err", 32'(err), 32'd0);
    expect_compute("ign", 1);
    check("ign_const", 32'(result), 32'd6);

    // clear two cycles into COMPUTE, with load_a pulsed in between.
    start_op(1'b1, acc);
    operand = 4'd9;
    load_a  = 1'b1;
    step();
    load_a  = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    do_clear("abort");
    load_b_op(4'd1);
    start_op(1'b0, acc);
    expect_reject("abort_aok");

    // Asynchronous reset between edges during COMPUTE.
    load_a_op(4'd7);
    load_b_op(4'd8);
    start_op(1'b0, acc);
    step();
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    step();
    model_reset();
    run_calc("post_rst", 4'd1, 4'd1, 1'b0);
    check("post_rst_const", 32'(result), 32'b00010);

    // Randomized sequences.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 7) == 0) do_clear("rnd_clear");
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) load_a_op(ra);
      if ($urandom_range(0, 3) != 0) load_b_op(rb);
      start_op(rs, acc);
      if (acc) expect_compute("rnd", 0);
      else     expect_reject("rnd_rej");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
